alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: requester count,
// opcode encodings and FSM state enumeration.
package alu_arbiter_pkg;

    localparam int unsigned NREQ = 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter requesters; opcodes 110/111 flag
// an error and return zero.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 first).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lat_a, lat_b;
    logic [2:0]       lat_op;
    logic             winner;
    logic [NREQ-1:0]  grant;
    logic             accept;
    logic             grant_idx;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry, alu_err;

`ifdef ALU_ARB_FIXED_PRI_EN
    always_comb begin
        grant = '0;
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
    end
`else
    logic last;

    // On contention the requester not granted last wins; a lone request always wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= 1'b1;
        else if (accept) last <= grant_idx;
    end
`endif

    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign grant_idx = req_ready[1];
    assign busy      = (state != IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready[winner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            winner     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_a  <= grant_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                lat_b  <= grant_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                lat_op <= grant_idx ? req_op[3 +: 3] : req_op[0 +: 3];
                winner <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_err    <= alu_err;
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (lat_a),
        .b      (lat_b),
        .op     (lat_op),
        .result (alu_result),
        .carry  (alu_carry),
        .err    (alu_err)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; honours ALU_ARB_FIXED_PRI_EN
// when choosing expected grants.
module tb_alu_arbiter;

    logic       clk, rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a, req_b;
    logic [5:0] req_op;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_err, busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic test_reset;
        #1;
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        total++; if (rsp_result !== 4'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", rsp_carry); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add;
        set_req(0, 4'd5, 4'd3, 3'b000);
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_req_ready got=%b exp=01", req_ready); end
        @(posedge clk);
        @(negedge clk) req_valid = 2'b00;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_exec_busy got=%b exp=1", busy); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL add_exec_rsp_valid got=%b exp=00", rsp_valid); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL add_exec_req_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid); end
        total++; if (rsp_result !== 4'd8) begin bad++; $display("FAIL add_result got=%h exp=8", rsp_result); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL add_carry got=%b exp=0", rsp_carry); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL add_err got=%b exp=0", rsp_err); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] va [2] = '{4'd9, 4'd2};
        logic [3:0] vb [2] = '{4'd8, 4'd6};
        logic [2:0] vo [2] = '{3'b000, 3'b001};
        logic [3:0] er [2] = '{4'b0001, 4'b1100};
        for (int k = 0; k < 2; k++) begin
            set_req(1, va[k], vb[k], vo[k]);
            req_valid = 2'b10; rsp_ready = 2'b11;
            #1;
            total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b%0d_req_ready got=%b exp=10", k, req_ready); end
            @(posedge clk);
            @(negedge clk) req_valid = 2'b00;
            @(negedge clk);
            total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL b2b%0d_rsp_valid got=%b exp=10", k, rsp_valid); end
            total++; if (rsp_result !== er[k]) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", k, rsp_result, er[k]); end
            total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL b2b%0d_carry got=%b exp=1", k, rsp_carry); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] g;
        logic [3:0] er;
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        set_req(0, 4'd1, 4'd1, 3'b000);
        set_req(1, 4'd7, 4'd2, 3'b001);
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            g = 2'b01;
`else
            g = (n % 2 == 1) ? 2'b10 : 2'b01;
`endif
            er = (g == 2'b01) ? 4'd2 : 4'd5;
            #1;
            total++; if (req_ready !== g) begin bad++; $display("FAIL rr%0d_grant got=%b exp=%b", n, req_ready, g); end
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            total++; if (rsp_valid !== g) begin bad++; $display("FAIL rr%0d_rsp_valid got=%b exp=%b", n, rsp_valid, g); end
            total++; if (rsp_result !== er) begin bad++; $display("FAIL rr%0d_result got=%h exp=%h", n, rsp_result, er); end
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_stall;
        set_req(0, 4'd6, 4'd3, 3'b100);
        req_valid = 2'b01; rsp_ready = 2'b00;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL stall_req_ready got=%b exp=01", req_ready); end
        @(posedge clk);
        @(negedge clk) begin req_valid = 2'b11; rsp_ready = 2'b10; end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL stall%0d_rsp_valid got=%b exp=01", c, rsp_valid); end
            total++; if (rsp_result !== 4'd5) begin bad++; $display("FAIL stall%0d_result got=%h exp=5", c, rsp_result); end
            total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL stall%0d_carry got=%b exp=0", c, rsp_carry); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL stall%0d_req_ready got=%b exp=00", c, req_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall%0d_busy got=%b exp=1", c, busy); end
            @(negedge clk);
        end
        req_valid = 2'b00; rsp_ready = 2'b01;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_release_busy got=%b exp=0", busy); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL stall_release_rsp_valid got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_err;
        set_req(0, 4'd9, 4'd9, 3'b111);
        req_valid = 2'b01; rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk) req_valid = 2'b00;
        @(negedge clk);
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL err_rsp_valid got=%b exp=01", rsp_valid); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", rsp_err); end
        total++; if (rsp_result !== 4'd0) begin bad++; $display("FAIL err_result got=%h exp=0", rsp_result); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL err_carry got=%b exp=0", rsp_carry); end
        @(negedge clk);
    endtask

    task automatic test_reset_exec;
        set_req(0, 4'd3, 4'd4, 3'b000);
        set_req(1, 4'd1, 4'd1, 3'b000);
        req_valid = 2'b01; rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk) req_valid = 2'b00;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstx_exec_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstx_busy got=%b exp=0", busy); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstx_rsp_valid got=%b exp=00", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rstx_err got=%b exp=0", rsp_err); end
        total++; if (rsp_result !== 4'd0) begin bad++; $display("FAIL rstx_result got=%h exp=0", rsp_result); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL rstx_carry got=%b exp=0", rsp_carry); end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstx_quiet%0d_rsp_valid got=%b exp=00", c, rsp_valid); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstx_quiet%0d_busy got=%b exp=0", c, busy); end
        end
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstx_first_grant got=%b exp=01", req_ready); end
        @(posedge clk);
        @(negedge clk) req_valid = 2'b00;
        @(negedge clk);
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rstx_after_rsp_valid got=%b exp=01", rsp_valid); end
        total++; if (rsp_result !== 4'd7) begin bad++; $display("FAIL rstx_after_result got=%h exp=7", rsp_result); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        test_reset;
        test_single_add;
        test_back_to_back;
        test_round_robin;
        test_stall;
        test_err;
        test_reset_exec;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
